// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receiver: FSM state encoding and channel
// select polarity of the word-select line.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_LEFT,
    ST_RIGHT
  } i2s_rx_state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for one asynchronous I2S pin, followed by a history flop
// so that a synchronized rising edge can be detected in the clk_sys domain.
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pin,
  output logic level_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_s = sync_q[SYNC_STAGES-1];
  assign rise    = level_s & ~hist_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples BCK/LRCK/DATA with clk_sys, deserializes MSB-first
// slots and presents left/right sample pairs with a one-cycle valid pulse.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    i2s_bck,
  input  logic                    i2s_lrck,
  input  logic                    i2s_data,
  output logic [SAMPLE_WIDTH-1:0] left,
  output logic [SAMPLE_WIDTH-1:0] right,
  output logic                    sample_valid,
  output logic                    frame_error
);

  localparam int                CNT_W = $clog2(SAMPLE_WIDTH + 1);
  localparam int                IDX_W = $clog2(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(SAMPLE_WIDTH);

  logic bck_rise;
  logic bck_level_unused;
  logic lrck_s;
  logic lrck_rise_unused;
  logic data_s;
  logic data_rise_unused;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bck (
    .clk_sys (clk_sys),
    .reset   (reset),
    .pin     (i2s_bck),
    .level_s (bck_level_unused),
    .rise    (bck_rise)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk_sys (clk_sys),
    .reset   (reset),
    .pin     (i2s_lrck),
    .level_s (lrck_s),
    .rise    (lrck_rise_unused)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk_sys (clk_sys),
    .reset   (reset),
    .pin     (i2s_data),
    .level_s (data_s),
    .rise    (data_rise_unused)
  );

  i2s_rx_state_t           state_q;
  logic [SAMPLE_WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ws_prev_q;
  logic [SAMPLE_WIDTH-1:0] left_hold_q;
  logic [IDX_W-1:0]        bit_idx;
  logic                    slot_close;
  logic                    slot_short;

  // NOTE: every combinational output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    bit_idx = IDX_W'(SAMPLE_WIDTH - 1) - cnt_q[IDX_W-1:0];
    if (cnt_q < FULL) begin
      sreg_d[bit_idx] = data_s;
      cnt_d           = cnt_q + CNT_W'(1);
    end
    slot_close = (lrck_s != ws_prev_q);
    slot_short = (cnt_d < FULL);
  end

  // The bit sampled on a word-select change is the LSB of the closing slot, so the
  // shifted word (sreg_d) is what gets handed to the FSM on a close.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_SYNC;
      sreg_q       <= '0;
      cnt_q        <= '0;
      ws_prev_q    <= 1'b0;
      left_hold_q  <= '0;
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (bck_rise) begin
        ws_prev_q <= lrck_s;
        if (slot_close) begin
          sreg_q <= '0;
          cnt_q  <= '0;
          unique case (state_q)
            ST_SYNC: begin
              if (lrck_s == CH_LEFT) state_q <= ST_LEFT;
            end
            ST_LEFT: begin
              left_hold_q <= sreg_d;
              if (slot_short) frame_error <= 1'b1;
              state_q <= ST_RIGHT;
            end
            ST_RIGHT: begin
              left         <= left_hold_q;
              right        <= sreg_d;
              sample_valid <= 1'b1;
              if (slot_short) frame_error <= 1'b1;
              state_q <= ST_LEFT;
            end
            default: state_q <= ST_SYNC;
          endcase
        end else begin
          sreg_q <= sreg_d;
          cnt_q  <= cnt_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: drives I2S slots from a bit-level transmitter task
// and compares every output pair against words computed from the transmitted slots.
module tb_i2s_rx;
  import i2s_pkg::*;

  localparam int SW = 16;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          bck     = 1'b1;
  logic          lrck    = 1'b0;
  logic          data    = 1'b0;
  logic [SW-1:0] left, right;
  logic          sample_valid, frame_error;

  int checks   = 0;
  int failures = 0;
  int half_ns  = 160;

  always #10 clk_sys = ~clk_sys;

  i2s_rx #(.SAMPLE_WIDTH(SW), .SYNC_STAGES(2)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .i2s_bck      (bck),
    .i2s_lrck     (lrck),
    .i2s_data     (data),
    .left         (left),
    .right        (right),
    .sample_valid (sample_valid),
    .frame_error  (frame_error)
  );

  logic [SW-1:0] got_l[$], got_r[$], exp_l[$], exp_r[$];
  int            wide_cnt = 0;
  int            hold_err = 0;
  logic          prev_valid = 1'b0;
  logic [SW-1:0] last_l = '0, last_r = '0;
  logic          exp_ferr = 1'b0;

  // Pulse collector: records each pair, flags pulses wider than one cycle and any
  // output change that is not accompanied by sample_valid.
  always @(negedge clk_sys) begin
    if (sample_valid) begin
      got_l.push_back(left);
      got_r.push_back(right);
      if (prev_valid) wide_cnt <= wide_cnt + 1;
    end else if (!reset && (left !== last_l || right !== last_r)) begin
      hold_err <= hold_err + 1;
    end
    prev_valid <= sample_valid;
    last_l     <= left;
    last_r     <= right;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word a receiver keeps from an n-bit MSB-first slot: top SW bits, zero-filled if short.
  function automatic logic [SW-1:0] slot_word(input logic [31:0] bits, input int n);
    if (n >= SW) return SW'(bits >> (n - SW));
    return SW'(bits << (SW - n));
  endfunction

  task automatic send_bit(input logic ws, input logic d);
    bck  = 1'b0;
    lrck = ws;
    data = d;
    #(half_ns);
    bck = 1'b1;
    #(half_ns);
  endtask

  // I2S framing: the slot's LSB is sent with word select already flipped.
  task automatic send_slot(input logic ch, input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 1; i--) send_bit(ch, bits[i]);
    send_bit(~ch, bits[0]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int nl, input int nr, input bit expect_pair);
    send_slot(CH_LEFT, l, nl);
    send_slot(CH_RIGHT, r, nr);
    if (expect_pair) begin
      exp_l.push_back(slot_word(l, nl));
      exp_r.push_back(slot_word(r, nr));
      if (nl < SW || nr < SW) exp_ferr = 1'b1;
    end
  endtask

  task automatic preamble();
    send_slot(CH_RIGHT, $urandom(), $urandom_range(2, 20));
  endtask

  task automatic align(input int phase);
    @(posedge clk_sys);
    #(phase);
  endtask

  task automatic settle();
    repeat (8) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset    = 1'b0;
    exp_ferr = 1'b0;
  endtask

  task automatic check_pairs(input string tag);
    int n;
    check({tag, " pulse count"}, got_l.size(), exp_l.size());
    n = (got_l.size() < exp_l.size()) ? got_l.size() : exp_l.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s left[%0d]", tag, i), got_l[i], exp_l[i]);
      check($sformatf("%s right[%0d]", tag, i), got_r[i], exp_r[i]);
    end
    check({tag, " wide pulses"}, wide_cnt, 0);
    check({tag, " hold violations"}, hold_err, 0);
    check({tag, " frame_error"}, frame_error, exp_ferr);
    got_l.delete();
    got_r.delete();
    exp_l.delete();
    exp_r.delete();
  endtask

  initial begin
    logic [31:0] lw, rw;

    // Reset state
    repeat (3) @(negedge clk_sys);
    check("reset left", left, 0);
    check("reset right", right, 0);
    check("reset sample_valid", sample_valid, 0);
    check("reset frame_error", frame_error, 0);
    reset = 1'b0;

    // Normal stream, 16 clk per bit, 32-bit slots
    half_ns = 160;
    align(5);
    preamble();
    send_frame({16'h1234, 16'($urandom())}, {16'hABCD, 16'($urandom())}, 32, 32, 1);
    settle();
    check_pairs("normal");

    // After reset: partial right slot first, then 8001/7FFE
    do_reset();
    check("post-reset left", left, 0);
    check("post-reset right", right, 0);
    align(5);
    preamble();
    send_frame({16'h8001, 16'($urandom())}, {16'h7FFE, 16'($urandom())}, 32, 32, 1);
    settle();
    check_pairs("after reset");

    // Short left slot (8 bits) followed by a full right slot; error is sticky
    do_reset();
    align(5);
    preamble();
    send_frame(32'h0000_00A5, $urandom(), 8, 32, 1);
    settle();
    check_pairs("short slot");
    send_frame($urandom(), $urandom(), 32, 32, 1);
    settle();
    check_pairs("sticky error");
    do_reset();
    @(negedge clk_sys);
    check("error cleared by reset", frame_error, 0);

    // Back-to-back counting pattern, slots of exactly SW bits
    half_ns = 80;
    align(5);
    preamble();
    for (int n = 0; n < 100; n++) begin
      lw = 32'(n[15:0]);
      rw = 32'(~n[15:0]);
      send_frame(lw, rw, 16, 16, 1);
    end
    settle();
    check_pairs("back-to-back");

    // Reset in the middle of a right slot
    half_ns = 160;
    do_reset();
    align(5);
    preamble();
    send_frame($urandom(), $urandom(), 32, 32, 1);
    send_slot(CH_LEFT, $urandom(), 32);
    for (int i = 0; i < 10; i++) send_bit(CH_RIGHT, 1'($urandom()));
    settle();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    align(5);
    for (int i = 0; i < 21; i++) send_bit(CH_RIGHT, 1'($urandom()));
    send_bit(CH_LEFT, 1'($urandom()));
    send_frame($urandom(), $urandom(), 32, 32, 1);
    settle();
    check_pairs("mid-frame reset");

    // Minimum ratio: 4 clk per bit, random pin-to-clock phase, random data
    half_ns = 40;
    do_reset();
    align($urandom_range(1, 19));
    preamble();
    for (int n = 0; n < 120; n++) send_frame($urandom(), $urandom(), 32, 32, 1);
    settle();
    check_pairs("min ratio");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
